lcd_init_seq: RTL and testbench



---
 rtl/lcd_init_seq.sv | 218 +++++++++++++++++++++
 tb/tb_lcd_init_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: power-up initialisation sequencer for an 8080-style 8-bit LCD.
// Pulses the panel hardware reset, then plays a fixed command/data/delay table
// on its own cs/dc/wr/data bus and finally raises init_done_o.
// Optional build macro LCD_INIT_AUTOSTART_EN: the first cycle after reset
// release acts as an implicit START_I.
module lcd_init_seq #(
    parameter int unsigned WR_LOW_CYC     = 2,
    parameter int unsigned WR_HIGH_CYC    = 2,
    parameter int unsigned HW_RST_CYC     = 500000,
    parameter int unsigned HW_WAIT_CYC    = 6000000,
    parameter int unsigned DELAY_UNIT_CYC = 50000
) (
    input  logic       SYS_CLK_I,
    input  logic       RESET_I,
    input  logic       START_I,
    output logic       lcd_rst_n_o,
    output logic       cs_o,
    output logic       dc_o,
    output logic       lcd_wr_o,
    output logic [7:0] data_o,
    output logic       busy_o,
    output logic       init_done_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HWRST  = 3'd1;
    localparam logic [2:0] S_HWWAIT = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_WRLO   = 3'd4;
    localparam logic [2:0] S_WRHI   = 3'd5;
    localparam logic [2:0] S_DELAY  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [1:0] T_CMD = 2'b00;
    localparam logic [1:0] T_DAT = 2'b01;
    localparam logic [1:0] T_DLY = 2'b10;
    localparam logic [1:0] T_END = 2'b11;

    // Last physical table slot; reaching it always terminates the sequence.
    localparam logic [3:0] TBL_LAST = 4'd9;

    localparam logic [31:0] RST_LAST  = 32'(HW_RST_CYC - 1);
    localparam logic [31:0] WAIT_LAST = 32'(HW_WAIT_CYC - 1);
    localparam logic [31:0] LO_LAST   = 32'(WR_LOW_CYC - 1);
    localparam logic [31:0] HI_LAST   = 32'(WR_HIGH_CYC - 1);
    localparam logic [39:0] DLY_UNIT  = 40'(DELAY_UNIT_CYC);

    // Fixed init table: {type[1:0], payload[7:0]}.
    function automatic logic [9:0] tbl_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    tbl_entry = {T_CMD, 8'h01};  // software reset
            4'd1:    tbl_entry = {T_DLY, 8'd5};
            4'd2:    tbl_entry = {T_CMD, 8'h11};  // sleep out
            4'd3:    tbl_entry = {T_DLY, 8'd120};
            4'd4:    tbl_entry = {T_CMD, 8'h3A};  // pixel format
            4'd5:    tbl_entry = {T_DAT, 8'h55};  // 16 bpp
            4'd6:    tbl_entry = {T_CMD, 8'h36};  // memory access control
            4'd7:    tbl_entry = {T_DAT, 8'h48};
            4'd8:    tbl_entry = {T_CMD, 8'h29};  // display on
            default: tbl_entry = {T_END, 8'h00};
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        dc_q, dc_d;
    logic [7:0]  data_q, data_d;
    logic        rst_n_q, cs_q, wr_q, busy_q, done_q;

    logic [9:0]  entry;
    logic [1:0]  etype;
    logic [7:0]  payload;
    logic [39:0] dly_len;
    logic [39:0] dly_last;
    logic        start_w;

    assign entry    = tbl_entry(idx_q);
    assign etype    = (idx_q >= TBL_LAST) ? T_END : entry[9:8];
    assign payload  = entry[7:0];
    // Full-width product so large delay payloads never wrap.
    assign dly_len  = {32'd0, payload} * DLY_UNIT;
    assign dly_last = dly_len - 40'd1;

`ifdef LCD_INIT_AUTOSTART_EN
    logic armed_q;

    // Goes high one cycle after reset release; until then an implicit start is requested.
    always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
        if (RESET_I) armed_q <= 1'b0;
        else         armed_q <= 1'b1;
    end

    assign start_w = START_I | ~armed_q;
`else
    assign start_w = START_I;
`endif

    // Next-state logic for the sequencer FSM, counter, table index and bus byte.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dc_d    = dc_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start_w) begin
                    state_d = S_HWRST;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_HWRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_HWWAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HWWAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_FETCH: begin
                cnt_d = '0;
                case (etype)
                    T_CMD, T_DAT: begin
                        state_d = S_WRLO;
                        dc_d    = etype[0];
                        data_d  = payload;
                    end
                    T_DLY: begin
                        // A zero-length delay just advances to the next entry.
                        if (payload == 8'd0) idx_d = idx_q + 4'd1;
                        else                 state_d = S_DELAY;
                    end
                    default: state_d = S_DONE;
                endcase
            end
            S_WRLO: begin
                if (cnt_q == LO_LAST) begin
                    state_d = S_WRHI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WRHI: begin
                if (cnt_q == HI_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    idx_d   = idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DELAY: begin
                if ({8'd0, cnt_q} == dly_last) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    idx_d   = idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                if (start_w) begin
                    state_d = S_HWRST;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; outputs are registered from the next state so they track it exactly.
    always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
        if (RESET_I) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dc_q    <= 1'b1;
            data_q  <= 8'h00;
            rst_n_q <= 1'b1;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dc_q    <= dc_d;
            data_q  <= data_d;
            rst_n_q <= (state_d != S_HWRST);
            cs_q    <= !((state_d == S_WRLO) || (state_d == S_WRHI));
            wr_q    <= (state_d != S_WRLO);
            busy_q  <= !((state_d == S_IDLE) || (state_d == S_DONE));
            done_q  <= (state_d == S_DONE);
        end
    end

    assign lcd_rst_n_o = rst_n_q;
    assign cs_o        = cs_q;
    assign dc_o        = dc_q;
    assign lcd_wr_o    = wr_q;
    assign data_o      = data_q;
    assign busy_o      = busy_q;
    assign init_done_o = done_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// tb_lcd_init_seq: bench for lcd_init_seq with shortened timing parameters.
module tb_lcd_init_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       lcd_rst_n;
    logic       cs;
    logic       dc;
    logic       wr;
    logic [7:0] data;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        int         gap;   // cycles since previous wr rising edge; 0 = not checked
    } byte_vec_t;

    byte_vec_t exp_tbl[7];
    byte_vec_t sb_q[$];
    int        last_rise;
    logic      prev_wr;

    lcd_init_seq #(
        .WR_LOW_CYC     (2),
        .WR_HIGH_CYC    (2),
        .HW_RST_CYC     (4),
        .HW_WAIT_CYC    (8),
        .DELAY_UNIT_CYC (10)
    ) dut (
        .SYS_CLK_I   (clk),
        .RESET_I     (rst),
        .START_I     (start),
        .lcd_rst_n_o (lcd_rst_n),
        .cs_o        (cs),
        .dc_o        (dc),
        .lcd_wr_o    (wr),
        .data_o      (data),
        .busy_o      (busy),
        .init_done_o (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_run();
        for (int i = 0; i < 7; i++) sb_q.push_back(exp_tbl[i]);
    endtask

    function automatic logic [13:0] snap();
        return {lcd_rst_n, cs, dc, wr, data, busy, done};
    endfunction

    // Write monitor: every rising wr edge with cs low is compared against the scoreboard.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (prev_wr === 1'b0 && wr === 1'b1 && cs === 1'b0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", {23'd0, dc, data}, 32'hFFFF);
            end else begin
                byte_vec_t e;
                e = sb_q.pop_front();
                check("wr_byte", {24'd0, data}, {24'd0, e.data});
                check("wr_dc", {31'd0, dc}, {31'd0, e.dc});
                if (e.gap != 0) check("wr_gap", 32'(cyc - last_rise), 32'(e.gap));
            end
            last_rise = cyc;
        end
        prev_wr = wr;
    end

    task automatic wait_done(input bit busy_pulses);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            start = busy_pulses && (n == 3 || n == 40 || n == 300 || n == 1000);
            tick();
            start = 1'b0;
            n++;
        end
        check("done_timeout", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_cs", {31'd0, cs}, 32'd1);
        check("done_data_hold", {24'd0, data}, 32'h29);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int act;
        // Expected write trace: dc, byte, gap from previous write.
        exp_tbl[0] = '{1'b0, 8'h01, 0};
        exp_tbl[1] = '{1'b0, 8'h11, 56};
        exp_tbl[2] = '{1'b0, 8'h3A, 1206};
        exp_tbl[3] = '{1'b1, 8'h55, 5};
        exp_tbl[4] = '{1'b0, 8'h36, 5};
        exp_tbl[5] = '{1'b1, 8'h48, 5};
        exp_tbl[6] = '{1'b0, 8'h29, 5};
        last_rise = 0;
        prev_wr   = 1'b1;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {18'd0, snap()}, {18'd0, 14'b1111_0000_0000_00});

`ifdef LCD_INIT_AUTOSTART_EN
        push_run();
        rst = 1'b0;
        tick();
        check("autostart_hwrst", {31'd0, lcd_rst_n}, 32'd0);
        wait_done(1'b0);
`else
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (busy || !lcd_rst_n || !cs || !wr || done) act++;
        end
        check("idle_no_start", 32'(act), 32'd0);
`endif

        // Start pulse: hardware reset, wait, then first command byte timing.
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (lcd_rst_n == 1'b0 && n < 100) begin n++; tick(); end
        check("hwrst_low_cyc", 32'(n), 32'd4);
        n = 0;
        while (cs == 1'b1 && n < 100) begin
            if (!lcd_rst_n) n = 1000;
            n++;
            tick();
        end
        check("hwwait_fetch_cyc", 32'(n), 32'd9);
        check("first_data", {24'd0, data}, 32'h01);
        check("first_dc", {31'd0, dc}, 32'd0);
        n = 0;
        while (wr == 1'b0 && cs == 1'b0 && n < 100) begin n++; tick(); end
        check("wr_low_cyc", 32'(n), 32'd2);
        n = 0;
        while (wr == 1'b1 && cs == 1'b0 && n < 100) begin n++; tick(); end
        check("wr_high_cyc", 32'(n), 32'd2);
        wait_done(1'b0);

        // Restart from DONE, with ignored START pulses during the replay.
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_done_clr", {31'd0, done}, 32'd0);
        check("restart_hwrst", {31'd0, lcd_rst_n}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(1'b1);

        // Asynchronous reset mid-run, with START held during reset.
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("midrun_busy", {31'd0, busy}, 32'd1);
        #2;
        rst   = 1'b1;
        start = 1'b1;
        #1;
        check("async_reset_outputs", {18'd0, snap()}, {18'd0, 14'b1111_0000_0000_00});
        sb_q.delete();
        repeat (3) tick();
        check("reset_hold_outputs", {18'd0, snap()}, {18'd0, 14'b1111_0000_0000_00});
        rst   = 1'b0;
        start = 1'b0;
`ifdef LCD_INIT_AUTOSTART_EN
        tick();
        check("autostart_after_reset", {31'd0, lcd_rst_n}, 32'd0);
`else
        act = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy || !lcd_rst_n || !cs || !wr || done) act++;
        end
        check("post_reset_idle", 32'(act), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
